// File: rtl/password_store_arbiter.sv
// Session arbiter for the single-port password store. Grants whole write or read
// sessions, alternates priority, reclaims stalled sessions and freezes on lock.
module password_store_arbiter #(
  parameter int unsigned ADDR_W  = 2,
  parameter int unsigned DATA_W  = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_last,
  output logic              wr_gnt,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_last,
  output logic              rd_gnt,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              lock_req,
  output logic [ADDR_W-1:0] store_addr,
  output logic              store_we,
  output logic [DATA_W-1:0] store_wdata,
  input  logic [DATA_W-1:0] store_rdata,
  output logic [1:0]        owner,
  output logic              session_abort
);

  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_WRITE  = 2'b01,
    S_READ   = 2'b10,
    S_LOCKED = 2'b11
  } state_e;

  state_e            state_q, state_d;
  logic              prio_rd_q, prio_rd_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              rd_valid_q;
  logic              abort_q, abort_d;
  logic [WD_W-1:0]   wd_inc;
  logic              timed_out;

  // Beat grants and the store-side mux
  always_comb begin
    wr_gnt      = (state_q == S_WRITE) && wr_req && !lock_req;
    rd_gnt      = (state_q == S_READ) && rd_req && !lock_req;
    store_we    = wr_gnt;
    store_addr  = '0;
    store_wdata = '0;
    if (wr_gnt) begin
      store_addr  = wr_addr;
      store_wdata = wr_data;
    end else if (rd_gnt) begin
      store_addr = rd_addr;
    end
  end

  assign rd_valid      = rd_valid_q;
  assign rd_data       = rd_valid_q ? store_rdata : '0;
  assign owner         = state_q;
  assign session_abort = abort_q;

  assign wd_inc    = wd_q + WD_W'(1);
  assign timed_out = (wd_inc == WD_W'(TIMEOUT));

  // Next-state: lock first, then session bookkeeping and the watchdog
  always_comb begin
    state_d   = state_q;
    prio_rd_d = prio_rd_q;
    wd_d      = wd_q;
    abort_d   = 1'b0;
    if (lock_req) begin
      state_d = S_LOCKED;
      abort_d = (state_q == S_WRITE) || (state_q == S_READ);
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (wr_req && (!rd_req || !prio_rd_q)) begin
            state_d = S_WRITE;
            wd_d    = '0;
          end else if (rd_req) begin
            state_d = S_READ;
            wd_d    = '0;
          end
        end
        S_WRITE: begin
          if (wr_gnt) begin
            wd_d = '0;
            if (wr_last) begin
              state_d   = S_IDLE;
              prio_rd_d = 1'b1;
            end
          end else if (timed_out) begin
            state_d   = S_IDLE;
            prio_rd_d = 1'b1;
            abort_d   = 1'b1;
          end else begin
            wd_d = wd_inc;
          end
        end
        S_READ: begin
          if (rd_gnt) begin
            wd_d = '0;
            if (rd_last) begin
              state_d   = S_IDLE;
              prio_rd_d = 1'b0;
            end
          end else if (timed_out) begin
            state_d   = S_IDLE;
            prio_rd_d = 1'b0;
            abort_d   = 1'b1;
          end else begin
            wd_d = wd_inc;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      prio_rd_q  <= 1'b0;
      wd_q       <= '0;
      rd_valid_q <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      prio_rd_q  <= prio_rd_d;
      wd_q       <= wd_d;
      rd_valid_q <= rd_gnt;
      abort_q    <= abort_d;
    end
  end

endmodule
